// File: rtl/disp_scan4.sv
// Four-digit time-multiplexed scanner feeding an MC14495 hex-to-segment decoder.
// Display content is double-buffered and only committed at frame boundaries.
module disp_scan4 #(
  parameter int SCAN_DIV     = 17,
  parameter int BLINK_FRAMES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] data,
  input  logic [3:0]  blank,
  input  logic [3:0]  dots,
  input  logic [3:0]  blink,
  output logic [3:0]  hex,
  output logic        LE,
  output logic        point,
  output logic [3:0]  AN,
  output logic        pending,
  output logic        frame_done
);

  localparam int BCW = $clog2(BLINK_FRAMES) + 1;
  localparam logic [SCAN_DIV-1:0] PRESC_MAX  = {SCAN_DIV{1'b1}};
  localparam logic [SCAN_DIV-1:0] PRESC_ZERO = {SCAN_DIV{1'b0}};
  localparam logic [BCW-1:0]      BLINK_LAST = BCW'(BLINK_FRAMES - 1);
  localparam logic [BCW-1:0]      BCNT_ZERO  = {BCW{1'b0}};

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  blank;
    logic [3:0]  dots;
    logic [3:0]  blink;
  } disp_t;

  // Shadow starts dark so nothing shows until the first committed load.
  localparam disp_t SHADOW_RST = {16'h0000, 4'b1111, 4'b0000, 4'b0000};
  localparam disp_t PEND_RST   = {16'h0000, 4'b0000, 4'b0000, 4'b0000};

  logic [SCAN_DIV-1:0] presc_q, presc_d;
  logic [1:0]          idx_q, idx_d;
  disp_t               shadow_q, shadow_d;
  disp_t               pend_set_q, pend_set_d;
  logic                pending_q, pending_d;
  logic [BCW-1:0]      bcnt_q, bcnt_d;
  logic                blink_phase_q, blink_phase_d;
  logic                frame_done_q, frame_done_d;

  logic tick;
  logic boundary;

  assign tick     = (presc_q == PRESC_MAX);
  assign boundary = tick & (idx_q == 2'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q       <= PRESC_ZERO;
      idx_q         <= 2'd0;
      shadow_q      <= SHADOW_RST;
      pend_set_q    <= PEND_RST;
      pending_q     <= 1'b0;
      bcnt_q        <= BCNT_ZERO;
      blink_phase_q <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      presc_q       <= presc_d;
      idx_q         <= idx_d;
      shadow_q      <= shadow_d;
      pend_set_q    <= pend_set_d;
      pending_q     <= pending_d;
      bcnt_q        <= bcnt_d;
      blink_phase_q <= blink_phase_d;
      frame_done_q  <= frame_done_d;
    end
  end

  always_comb begin
    presc_d       = presc_q;
    idx_d         = idx_q;
    shadow_d      = shadow_q;
    pend_set_d    = pend_set_q;
    pending_d     = pending_q;
    bcnt_d        = bcnt_q;
    blink_phase_d = blink_phase_q;
    frame_done_d  = boundary;

    if (tick) begin
      presc_d = PRESC_ZERO;
      idx_d   = idx_q + 2'd1;
    end else begin
      presc_d = presc_q + SCAN_DIV'(1);
      idx_d   = idx_q;
    end

    // Commit uses the pending set as it stood before this edge; a coinciding
    // load below only refills the buffer for the next boundary.
    if (boundary) begin
      if (pending_q) begin
        shadow_d  = pend_set_q;
        pending_d = 1'b0;
      end else begin
        shadow_d  = shadow_q;
      end
      if (bcnt_q == BLINK_LAST) begin
        bcnt_d        = BCNT_ZERO;
        blink_phase_d = ~blink_phase_q;
      end else begin
        bcnt_d        = bcnt_q + BCW'(1);
      end
    end else begin
      shadow_d = shadow_q;
    end

    if (load) begin
      pend_set_d = {data, blank, dots, blink};
      pending_d  = 1'b1;
    end else begin
      pend_set_d = pend_set_q;
    end
  end

  always_comb begin
    AN         = ~(4'b0001 << idx_q);
    hex        = shadow_q.data[{idx_q, 2'b00} +: 4];
    point      = shadow_q.dots[idx_q];
    LE         = shadow_q.blank[idx_q] | (shadow_q.blink[idx_q] & blink_phase_q);
    pending    = pending_q;
    frame_done = frame_done_q;
  end

endmodule

// File: doc/disp_scan4.md
Name: disp_scan4

Overview:
- Four-digit time-multiplexed scanner for the seven-segment display; sits directly upstream of the MC14495 hex-to-segment decoder.
- Holds a 16-bit hex value plus per-digit blank, dot and blink masks, and cycles one digit at a time.
- Drives the decoder's nibble (D3..D0), LE and point inputs together with the active-low anode selects.
- New display content is double-buffered and committed only at frame boundaries, so no digit ever shows a torn value.

Parameters:
- SCAN_DIV, 17, prescaler width; the digit advances every 2^SCAN_DIV clocks.
- BLINK_FRAMES, 64, number of complete frames per blink half-period; must be >= 1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- load  in  1  single-cycle strobe; captures data/blank/dots/blink into the pending buffer
- data  in  16  hex value; digit i = data[4i+3:4i], digit 0 is the rightmost
- blank  in  4  1 = digit i dark
- dots  in  4  1 = decimal point of digit i lit
- blink  in  4  1 = digit i blinks
- hex  out  4  nibble to the decoder D3..D0
- LE  out  1  decoder blank; 1 = all segments off
- point  out  1  decoder point input; 1 = dot lit (decoder inverts it to the active-low p)
- AN  out  4  anode selects, active-low, one-hot-zero
- pending  out  1  pending buffer holds an uncommitted load
- frame_done  out  1  one-cycle pulse at each frame boundary

Behaviour:
- Only one clock and one synchronous active-high reset exist; there are no other clock or reset domains.
- State registers:
  - presc (SCAN_DIV bits)
  - idx (2 bits)
  - shadow set and pending set, each holding data, blank, dots and blink
  - pending flag
  - blink frame counter and blink_phase
  - frame_done
- Reset values:
  - presc=0, idx=0
  - shadow: data=0, blank=4'b1111, dots=0, blink=0
  - pending set all zero; pending=0
  - blink counter=0, blink_phase=0, frame_done=0
  - Resulting outputs: AN=4'b1110, hex=0, LE=1, point=0.
- Reset mid-frame discards the pending buffer and the shadow set, restarts at digit 0 and leaves the display dark.
- tick is true when presc == 2^SCAN_DIV-1.
  - On a tick edge: presc←0 and idx←idx+1 (3 wraps to 0).
  - Otherwise presc←presc+1.
- A frame is 4 ticks, i.e. 4·2^SCAN_DIV clocks. The boundary is the tick edge at which idx goes 3→0.
- Outputs are pure functions of registered state; there is no combinational path from any input to any output. For digit i=idx:
  - AN = ~(1<<i)
  - hex = shadow.data[4i+3:4i]
  - point = shadow.dots[i]
  - LE = shadow.blank[i] | (shadow.blink[i] & blink_phase)
- Load handling:
  - A load edge writes all four input fields into the pending set and sets pending=1.
  - A load while pending=1 overwrites the pending set; the last load wins.
- Commit at the boundary edge:
  - If pending=1 before the edge, shadow←pending set and pending←0.
  - If load coincides with the boundary edge, the old pending contents (if any) are committed and the new load is stored as pending. pending ends at 1 and the new value is committed at the next boundary.
- frame_done is registered: it is 1 for exactly the cycle following a boundary edge, and 0 otherwise.
- Blink:
  - The frame counter increments at each boundary.
  - When it reaches BLINK_FRAMES-1 at a boundary, it resets to 0 and blink_phase toggles on that same edge.
  - blink_phase is not affected by load or commit.
- Width rules:
  - presc wraps modulo 2^SCAN_DIV.
  - The blink counter is $clog2(BLINK_FRAMES)+1 bits wide, with no overflow.

Test Plan (SCAN_DIV=2, BLINK_FRAMES=2):
- Reset, then idle 20 clocks:
  - AN=1110 for clocks 0–3, 1101 for 4–7, 1011 for 8–11, 0111 for 12–15, 1110 again at 16.
  - LE=1 throughout; frame_done high only at clock 16.
- At clock 2, load data=16'h3A7C, blank=0, dots=4'b0100, blink=0:
  - pending=1 until the boundary at clock 16.
  - From clock 16: digit0 hex=C, digit1 7, digit2 A with point=1, digit3 3; LE=0.
- Two loads at clocks 3 and 5 (16'h1111, then 16'h2222): the frame after the boundary shows 2 on every digit; 1 never appears.
- Load 16'hBEEF asserted exactly on a boundary edge with pending=0:
  - Display keeps the old value for one more frame.
  - pending=1 throughout that frame.
  - BEEF appears after the next boundary.
- blink=4'b0001, blank=0 committed: digit0 LE alternates 0 for 2 frames, 1 for 2 frames; digits 1–3 keep LE=0.
- Assert rst for 1 clock while idx=2 with a pending load:
  - Next cycle AN=1110, LE=1, pending=0.
  - The pending value never reaches the display.
